// File: rtl/demux_1x8_capture.sv
// Serial-to-parallel receiver for mux_8X1 scan-out: steers din into one bit of
// an 8-bit word, either by an external select or by an LSB-first sequencer.
module demux_1x8_capture (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       din,
  input  logic [2:0] sel,
  input  logic       mode,
  input  logic       start,
  output logic [7:0] a,
  output logic [2:0] cnt,
  output logic       busy,
  output logic       valid
);

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t     state_r;
  logic [7:0] a_r;
  logic [2:0] cnt_r;
  logic       busy_r;
  logic       valid_r;

  // Capture FSM and all registered outputs; valid is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= 8'h00;
      cnt_r   <= 3'd0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (!mode) begin
        // Direct mode; leaving auto mode mid-word aborts the sequencer.
        state_r <= IDLE;
        busy_r  <= 1'b0;
        if (state_r == CAPTURE) begin
          cnt_r <= 3'd0;
        end else begin
          cnt_r <= cnt_r;
        end
        if (enable) begin
          a_r[sel] <= din;
        end else begin
          a_r <= a_r;
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              a_r     <= 8'h00;
              cnt_r   <= 3'd0;
              state_r <= CAPTURE;
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
          CAPTURE: begin
            if (start) begin
              // Restart wins over capture; din is dropped on this edge.
              a_r     <= 8'h00;
              cnt_r   <= 3'd0;
              state_r <= CAPTURE;
              busy_r  <= 1'b1;
            end else if (enable) begin
              a_r[cnt_r] <= din;
              cnt_r      <= cnt_r + 3'd1;
              if (cnt_r == 3'd7) begin
                valid_r <= 1'b1;
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end else begin
                state_r <= CAPTURE;
                busy_r  <= 1'b1;
              end
            end else begin
              state_r <= CAPTURE;
              busy_r  <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign a     = a_r;
  assign cnt   = cnt_r;
  assign busy  = busy_r;
  assign valid = valid_r;

endmodule

// File: tb/tb_demux_1x8_capture.sv
// Directed and randomized checks of demux_1x8_capture against expectations
// derived from the word-level behaviour of the block.
module tb_demux_1x8_capture;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       din;
  logic [2:0] sel;
  logic       mode;
  logic       start;
  logic [7:0] a;
  logic [2:0] cnt;
  logic       busy;
  logic       valid;

  int checks;
  int errors;

  demux_1x8_capture dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .din    (din),
    .sel    (sel),
    .mode   (mode),
    .start  (start),
    .a      (a),
    .cnt    (cnt),
    .busy   (busy),
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] word;
    logic [7:0] model;
    logic [7:0] rbyte;
    logic       d;
    logic [2:0] s;
    int         k;
    int         vcount;
    logic       en;

    checks = 0;
    errors = 0;
    rst = 1'b1; enable = 1'b0; din = 1'b0; sel = 3'd0; mode = 1'b0; start = 1'b0;
    #12;
    rst = 1'b0;
    chk("rst_a", a, 8'h00);
    chk("rst_cnt", {5'd0, cnt}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_valid", {7'd0, valid}, 8'd0);

    // Direct mode: rebuild 8'h54 bit by bit.
    pat = 8'h54;
    mode = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i); din = pat[i];
      tick();
      chk("dir_valid", {7'd0, valid}, 8'd0);
    end
    chk("dir_a", a, 8'h54);
    chk("dir_busy", {7'd0, busy}, 8'd0);
    enable = 1'b0; sel = 3'd3; din = 1'b1;
    tick();
    chk("dir_hold", a, 8'h54);

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_a", a, 8'h00);
    chk("arst_cnt", {5'd0, cnt}, 8'd0);
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_valid", {7'd0, valid}, 8'd0);
    #1;
    rst = 1'b0;

    // Auto capture of 8'h96 with continuous enable.
    word = 8'h96;
    mode = 1'b1; start = 1'b1; enable = 1'b0;
    tick();
    chk("auto_start_busy", {7'd0, busy}, 8'd1);
    chk("auto_start_a", a, 8'h00);
    start = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = word[i];
      tick();
      if (i < 7) begin
        chk("auto_cnt", {5'd0, cnt}, 8'(i + 1));
        chk("auto_busy", {7'd0, busy}, 8'd1);
        chk("auto_novalid", {7'd0, valid}, 8'd0);
      end else begin
        chk("auto_a", a, 8'h96);
        chk("auto_valid", {7'd0, valid}, 8'd1);
        chk("auto_busy_fall", {7'd0, busy}, 8'd0);
        chk("auto_cnt_wrap", {5'd0, cnt}, 8'd0);
      end
    end
    enable = 1'b0;
    tick();
    chk("auto_valid_clear", {7'd0, valid}, 8'd0);
    chk("auto_a_hold", a, 8'h96);

    // Stall for 3 cycles after the 4th bit; valid arrives 11 edges after start.
    start = 1'b1;
    tick();
    start = 1'b0;
    vcount = 0;
    for (int t = 0; t < 11; t++) begin
      en = !(t >= 4 && t < 7);
      k = (t < 4) ? t : ((t < 7) ? 4 : t - 3);
      enable = en; din = word[k[2:0]];
      tick();
      if (valid) vcount++;
      if (t >= 4 && t < 7) begin
        chk("stall_cnt", {5'd0, cnt}, 8'd4);
        chk("stall_hi", {4'd0, a[7:4]}, 8'd0);
      end else begin
        chk("stall_valid", {7'd0, valid}, (t == 10) ? 8'd1 : 8'd0);
      end
    end
    chk("stall_a", a, 8'h96);
    chk("stall_vcount", 8'(vcount), 8'd1);

    // Restart after 5 bits, then abort via mode after 2 bits.
    enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; din = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_restart_cnt", {5'd0, cnt}, 8'd5);
    start = 1'b1;
    tick();
    chk("restart_a", a, 8'h00);
    chk("restart_cnt", {5'd0, cnt}, 8'd0);
    chk("restart_busy", {7'd0, busy}, 8'd1);
    chk("restart_valid", {7'd0, valid}, 8'd0);
    start = 1'b0;
    tick();
    tick();
    chk("partial_a", a, 8'h03);
    mode = 1'b0; enable = 1'b0;
    tick();
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_cnt", {5'd0, cnt}, 8'd0);
    chk("abort_a", a, 8'h03);
    chk("abort_valid", {7'd0, valid}, 8'd0);

    // Random direct-mode writes against a byte model.
    model = 8'h03;
    enable = 1'b1;
    for (int i = 0; i < 11; i++) begin
      d = 1'($urandom_range(0, 1));
      s = 3'($urandom_range(0, 7));
      din = d; sel = s;
      model[s] = d;
      tick();
      chk("rand_dir", a, model);
      chk("rand_dir_valid", {7'd0, valid}, 8'd0);
    end

    // Random byte in auto mode with random enable stalls.
    rbyte = 8'($urandom);
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    vcount = 0;
    for (int t = 0; t < 200 && k < 8; t++) begin
      en = 1'($urandom_range(0, 1));
      enable = en; din = rbyte[k[2:0]];
      tick();
      if (en) k++;
      if (valid) vcount++;
    end
    chk("rand_done", 8'(k), 8'd8);
    chk("rand_auto_a", a, rbyte);
    enable = 1'b0;
    tick();
    if (valid) vcount++;
    chk("rand_vcount", 8'(vcount), 8'd1);
    chk("rand_busy", {7'd0, busy}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
